csr_wr_unit: RTL
================

CSR_WR_UNIT -- requirements
Module: csr_wr_unit

Interface
REQ-001 SHALL have parameter MTVEC_RST, default 32'h0000_0000, the mtvec value after reset.
REQ-002 SHALL have port clk  input  1  the single core clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port state  input  3  core phase, encoded per the shared constants header.
REQ-005 SHALL have port en_csr  input  1  the current instruction is a CSR instruction.
REQ-006 SHALL have port csr_op  input  2  operation: 01 = RW, 10 = RS, 11 = RC; 00 = no-op.
REQ-007 SHALL have port csr_adr  input  12  CSR address.
REQ-008 SHALL have port wr_src  input  32  rs1 value or zero-extended uimm.
REQ-009 SHALL have port src_zero  input  1  rs1/uimm index is x0/0.
REQ-010 SHALL have port trap  input  1  trap-entry strobe.
REQ-011 SHALL have port trap_pc  input  32  PC to save on trap.
REQ-012 SHALL have port trap_cause  input  32  cause to save on trap.
REQ-013 SHALL have port retire  input  1  one-cycle instruction-retired pulse.
REQ-014 SHALL have port csr_rdata  output  32  old CSR value, returned to rd.
REQ-015 SHALL have port csr_illegal  output  1  illegal CSR access.
REQ-016 SHALL have port mtvec_o  output  32  current mtvec.
REQ-017 SHALL have port mepc_o  output  32  current mepc.
REQ-018 SHALL have port mie_o  output  1  mstatus.MIE.

Function
REQ-019 SHALL implement mstatus 0x300 (only bit 3 MIE writable, other bits read 0), mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342.
REQ-020 SHALL latch csr_rdata and csr_illegal on the edge where state==`REG_FILE_READ and en_csr; both hold until the next such edge.
REQ-021 SHALL commit writes on the edge where state==`WRITE_BACK, en_csr, write_req, and the latched csr_illegal is low.
REQ-022 SHALL define write_req as: RW always; RS/RC only when src_zero is low; 00 never.
REQ-023 SHALL compute the new value as RW: wr_src; RS: old|wr_src; RC: old&~wr_src, where old is the latched csr_rdata.
REQ-024 SHALL force mepc[1:0] and mtvec[1:0] to 00 on every write.
REQ-025 SHALL flag csr_illegal for an unimplemented address, or when write_req is high and csr_adr[11:10]==2'b11.
REQ-026 SHALL, on trap, set mepc=trap_pc&~3, set mcause=trap_cause, and clear MIE in the same edge; trap wins over a same-cycle CSR write to any register.
REQ-027 SHALL drive mtvec_o, mepc_o and mie_o directly from the registers, with no added latency.

Reset
REQ-028 SHALL on rst_n low immediately set: mtvec=MTVEC_RST; mstatus, mscratch, mepc, mcause, csr_rdata, csr_illegal and minstret to 0.
REQ-029 SHALL, when reset is asserted mid-instruction, discard the pending write; the first instruction after release behaves as fresh.

Configuration
REQ-030 SHALL, with CSR_MINSTRET_EN defined, implement the 64-bit minstret counter: 0xB02 (low), 0xB82 (high), and read-only aliases 0xC02/0xC82.
REQ-031 SHALL increment minstret by 1 on retire, carrying from the low half into the high half; a same-edge CSR write to either half wins over the increment for the whole 64-bit value.
REQ-032 SHALL, without CSR_MINSTRET_EN, treat all four addresses as unimplemented (csr_illegal set) and contain no counter logic.

Structure
REQ-033 SHALL take `REG_FILE_READ, `WRITE_BACK, the CSR address constants and the csr_op encodings from the shared constants header; no local redefinitions.
REQ-034 SHALL place minstret in sub-module csr_cnt64 (load-low, load-high, increment, 64-bit value out), instantiated only under CSR_MINSTRET_EN.

Verification
REQ-035 SHALL cover: RW 0x340 with wr_src=0xDEADBEEF, then RS 0x340 with 0x0000_0010 -> first csr_rdata=0, second csr_rdata=0xDEADBEEF, mscratch becomes 0xDEADBEFF.
REQ-036 SHALL cover: RC 0x300 with src_zero=1 after MIE=1 -> csr_rdata=0x8, no write, MIE stays 1.
REQ-037 SHALL cover: RW 0xC02 with src_zero=0 -> csr_illegal=1, no state change; RS 0xC02 with src_zero=1 -> csr_illegal=0.
REQ-038 SHALL cover: RW 0x341 with 0x1003 in the same edge as trap with trap_pc=0x2006 -> mepc=0x2004, MIE=0.
REQ-039 SHALL cover (CSR_MINSTRET_EN): load low=0xFFFF_FFFF, then retire pulse -> high=1, low=0; write high on a retire edge -> written value kept, no increment.
REQ-040 SHALL cover: assert rst_n low during `WRITE_BACK of an RW to mtvec -> mtvec=MTVEC_RST after release.

Source files
------------

// File: rtl/csr_wr_unit_pkg.sv
// Shared constants header (core phases, CSR addresses, csr_op encodings) and the
// CSR select type and read-modify-write helper used by csr_wr_unit.
`ifndef CSR_WR_UNIT_CONSTS
`define CSR_WR_UNIT_CONSTS
`define FETCH          3'd0
`define DECODE         3'd1
`define REG_FILE_READ  3'd2
`define EXECUTE        3'd3
`define MEMORY         3'd4
`define WRITE_BACK     3'd5

`define CSR_MSTATUS    12'h300
`define CSR_MTVEC      12'h305
`define CSR_MSCRATCH   12'h340
`define CSR_MEPC       12'h341
`define CSR_MCAUSE     12'h342
`define CSR_MINSTRET   12'hB02
`define CSR_MINSTRETH  12'hB82
`define CSR_INSTRET    12'hC02
`define CSR_INSTRETH   12'hC82

`define CSR_OP_NOP     2'b00
`define CSR_OP_RW      2'b01
`define CSR_OP_RS      2'b10
`define CSR_OP_RC      2'b11
`endif

package csr_wr_unit_pkg;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MSTATUS,
    SEL_MTVEC,
    SEL_MSCRATCH,
    SEL_MEPC,
    SEL_MCAUSE,
    SEL_INSTRET_LO,
    SEL_INSTRET_HI
  } csr_sel_e;

  localparam int unsigned MIE_BIT = 3;

  function automatic logic [31:0] csr_modify(input logic [1:0]  op,
                                             input logic [31:0] old_val,
                                             input logic [31:0] src);
    logic [31:0] res;
    res = old_val;
    case (op)
      `CSR_OP_RW: res = src;
      `CSR_OP_RS: res = old_val | src;
      `CSR_OP_RC: res = old_val & ~src;
      default:    res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_cnt64.sv
// 64-bit retired-instruction counter; a load of either half takes priority over
// the increment for the whole 64-bit value.
module csr_cnt64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_lo,
  input  logic        ld_hi,
  input  logic [31:0] ld_val,
  input  logic        inc,
  output logic [63:0] value
);

  logic [63:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (ld_lo) begin
      cnt_q[31:0] <= ld_val;
    end else if (ld_hi) begin
      cnt_q[63:32] <= ld_val;
    end else if (inc) begin
      cnt_q <= cnt_q + 64'd1;
    end
  end

  assign value = cnt_q;

endmodule

// File: rtl/csr_wr_unit.sv
// Machine-mode CSR read/write unit: mstatus.MIE, mtvec, mscratch, mepc, mcause,
// plus the minstret counter when CSR_MINSTRET_EN is defined.
module csr_wr_unit
  import csr_wr_unit_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  state,
  input  logic        en_csr,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_adr,
  input  logic [31:0] wr_src,
  input  logic        src_zero,
  input  logic        trap,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic        retire,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        mie_o
);

  csr_sel_e    sel;
  logic [31:0] rd_val;
  logic [31:0] new_val;
  logic        write_req;
  logic        illegal_now;
  logic        pending_q;
  logic        commit;

  logic        mie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;

`ifdef CSR_MINSTRET_EN
  logic [63:0] instret;
`else
  logic        unused_retire;
  assign unused_retire = retire;
`endif

  always_comb begin
    sel = SEL_NONE;
    case (csr_adr)
      `CSR_MSTATUS:  sel = SEL_MSTATUS;
      `CSR_MTVEC:    sel = SEL_MTVEC;
      `CSR_MSCRATCH: sel = SEL_MSCRATCH;
      `CSR_MEPC:     sel = SEL_MEPC;
      `CSR_MCAUSE:   sel = SEL_MCAUSE;
`ifdef CSR_MINSTRET_EN
      `CSR_MINSTRET:  sel = SEL_INSTRET_LO;
      `CSR_MINSTRETH: sel = SEL_INSTRET_HI;
      `CSR_INSTRET:   sel = SEL_INSTRET_LO;
      `CSR_INSTRETH:  sel = SEL_INSTRET_HI;
`endif
      default:       sel = SEL_NONE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    case (sel)
      SEL_MSTATUS:    rd_val[MIE_BIT] = mie_q;
      SEL_MTVEC:      rd_val = mtvec_q;
      SEL_MSCRATCH:   rd_val = mscratch_q;
      SEL_MEPC:       rd_val = mepc_q;
      SEL_MCAUSE:     rd_val = mcause_q;
`ifdef CSR_MINSTRET_EN
      SEL_INSTRET_LO: rd_val = instret[31:0];
      SEL_INSTRET_HI: rd_val = instret[63:32];
`endif
      default:        rd_val = '0;
    endcase
  end

  // RS/RC with an x0/zero source are pure reads and never count as writes.
  assign write_req = (csr_op == `CSR_OP_RW) ||
                     (((csr_op == `CSR_OP_RS) || (csr_op == `CSR_OP_RC)) && !src_zero);
  assign illegal_now = (sel == SEL_NONE) || (write_req && (csr_adr[11:10] == 2'b11));
  assign new_val     = csr_modify(csr_op, csr_rdata, wr_src);

  // pending_q ties a write-back to a read of the same instruction, so a
  // write-back left over from before a reset can never commit.
  assign commit = (state == `WRITE_BACK) && en_csr && write_req && !csr_illegal &&
                  pending_q && !trap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_rdata   <= '0;
      csr_illegal <= 1'b0;
      pending_q   <= 1'b0;
    end else if ((state == `REG_FILE_READ) && en_csr) begin
      csr_rdata   <= rd_val;
      csr_illegal <= illegal_now;
      pending_q   <= 1'b1;
    end else if ((state == `WRITE_BACK) && en_csr) begin
      pending_q   <= 1'b0;
    end
  end

  // Trap entry takes precedence over any CSR write in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q      <= 1'b0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else if (trap) begin
      mie_q    <= 1'b0;
      mepc_q   <= trap_pc & ~32'd3;
      mcause_q <= trap_cause;
    end else if (commit) begin
      case (sel)
        SEL_MSTATUS:  mie_q      <= new_val[MIE_BIT];
        SEL_MTVEC:    mtvec_q    <= {new_val[31:2], 2'b00};
        SEL_MSCRATCH: mscratch_q <= new_val;
        SEL_MEPC:     mepc_q     <= {new_val[31:2], 2'b00};
        SEL_MCAUSE:   mcause_q   <= new_val;
        default:      ;
      endcase
    end
  end

`ifdef CSR_MINSTRET_EN
  csr_cnt64 u_minstret (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld_lo  (commit && (sel == SEL_INSTRET_LO)),
    .ld_hi  (commit && (sel == SEL_INSTRET_HI)),
    .ld_val (new_val),
    .inc    (retire),
    .value  (instret)
  );
`endif

  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;
  assign mie_o   = mie_q;

endmodule
